// File: rtl/renode_ahb_arbiter.sv
// rtl/renode_ahb_arbiter.sv - AHB-Lite N-manager to 1-subordinate bus arbiter
//
// Shares one AHB-Lite subordinate port between NUM_MANAGERS managers. Ownership
// is registered: a requester gets the shared bus one cycle after its request is
// first seen, and keeps it until it drives IDLE on a ready edge, so bursts and
// back-to-back NONSEQ transfers are never split.
//
// Configuration macro:
//   RENODE_AHB_ARB_FIXED_PRIO_EN  defined: lowest-index requester wins
//                                 undefined: round-robin from last grant + 1
//
// Ports:
//   HCLK, HRESETn      bus clock, asynchronous active-low reset
//   m_htrans..m_hwdata per-manager request side, manager i in slice i
//   m_hready, m_hresp  per-manager response, only the owner sees activity
//   m_hrdata           subordinate read data, broadcast to all managers
//   s_htrans..s_hwdata muxed shared-bus address/control/write data
//   s_hready           shared-bus HREADY (= s_hreadyout)
//   s_hreadyout        subordinate HREADYOUT
//   s_hresp, s_hrdata  subordinate response and read data
//   s_hmaster          address-phase owner index, 0 while nobody owns the bus
module renode_ahb_arbiter #(
  parameter int NUM_MANAGERS = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  localparam int IW          = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [2*NUM_MANAGERS-1:0]        m_htrans,
  input  logic [ADDR_WIDTH*NUM_MANAGERS-1:0] m_haddr,
  input  logic [NUM_MANAGERS-1:0]          m_hwrite,
  input  logic [3*NUM_MANAGERS-1:0]        m_hsize,
  input  logic [3*NUM_MANAGERS-1:0]        m_hburst,
  input  logic [DATA_WIDTH*NUM_MANAGERS-1:0] m_hwdata,
  output logic [NUM_MANAGERS-1:0]          m_hready,
  output logic [NUM_MANAGERS-1:0]          m_hresp,
  output logic [DATA_WIDTH-1:0]            m_hrdata,
  output logic [1:0]                       s_htrans,
  output logic [ADDR_WIDTH-1:0]            s_haddr,
  output logic                             s_hwrite,
  output logic [2:0]                       s_hsize,
  output logic [2:0]                       s_hburst,
  output logic [DATA_WIDTH-1:0]            s_hwdata,
  output logic                             s_hready,
  input  logic                             s_hreadyout,
  input  logic                             s_hresp,
  input  logic [DATA_WIDTH-1:0]            s_hrdata,
  output logic [IW-1:0]                    s_hmaster
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   addr_owner, addr_owner_next;
  logic [IW-1:0]   data_owner, data_owner_next;
  // data_valid marks a data phase that belongs to a granted address phase;
  // without it s_hwdata would leak manager 0's write data out of reset.
  logic            data_valid, data_valid_next;
`ifndef RENODE_AHB_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   last_grant, last_grant_next;
  logic [IW-1:0]   rr_idx;
`endif

  logic [NUM_MANAGERS-1:0] req;
  logic                    any_req;
  logic [IW-1:0]           winner;
  logic [1:0]              owner_htrans;

  logic [1:0]            htrans_a [NUM_MANAGERS];
  logic [ADDR_WIDTH-1:0] haddr_a  [NUM_MANAGERS];
  logic [2:0]            hsize_a  [NUM_MANAGERS];
  logic [2:0]            hburst_a [NUM_MANAGERS];
  logic [DATA_WIDTH-1:0] hwdata_a [NUM_MANAGERS];

  // Unpack the flat per-manager buses; NONSEQ/SEQ (bit 1 set) is a request.
  always_comb begin
    for (int i = 0; i < NUM_MANAGERS; i++) begin
      htrans_a[i] = m_htrans[2*i +: 2];
      haddr_a[i]  = m_haddr[ADDR_WIDTH*i +: ADDR_WIDTH];
      hsize_a[i]  = m_hsize[3*i +: 3];
      hburst_a[i] = m_hburst[3*i +: 3];
      hwdata_a[i] = m_hwdata[DATA_WIDTH*i +: DATA_WIDTH];
      req[i]      = m_htrans[2*i+1];
    end
  end

  assign any_req      = |req;
  assign owner_htrans = htrans_a[addr_owner];

  // Winner selection. Loops run from lowest to highest priority so the last
  // matching assignment is the one that sticks.
  always_comb begin
    winner = '0;
`ifdef RENODE_AHB_ARB_FIXED_PRIO_EN
    for (int k = NUM_MANAGERS - 1; k >= 0; k--) begin
      if (req[k]) winner = IW'(k);
    end
`else
    rr_idx = '0;
    // k = NUM_MANAGERS lands on last_grant itself, the lowest priority slot.
    for (int k = NUM_MANAGERS; k >= 1; k--) begin
      rr_idx = IW'((int'(last_grant) + k) % NUM_MANAGERS);
      if (req[rr_idx]) winner = rr_idx;
    end
`endif
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      addr_owner <= '0;
      data_owner <= '0;
      data_valid <= 1'b0;
`ifndef RENODE_AHB_ARB_FIXED_PRIO_EN
      last_grant <= '0;
`endif
    end else begin
      state      <= state_next;
      addr_owner <= addr_owner_next;
      data_owner <= data_owner_next;
      data_valid <= data_valid_next;
`ifndef RENODE_AHB_ARB_FIXED_PRIO_EN
      last_grant <= last_grant_next;
`endif
    end
  end

  // Next state. Everything is frozen while the subordinate stalls; ownership
  // only moves on a ready edge where the owner is idle (or nobody owns).
  // SEQ and BUSY keep the grant, which keeps bursts intact.
  always_comb begin
    state_next      = state;
    addr_owner_next = addr_owner;
    data_owner_next = data_owner;
    data_valid_next = data_valid;
`ifndef RENODE_AHB_ARB_FIXED_PRIO_EN
    last_grant_next = last_grant;
`endif
    if (s_hreadyout) begin
      data_owner_next = addr_owner;
      data_valid_next = (state == ST_OWNED);
      if (state == ST_IDLE || owner_htrans == HTRANS_IDLE) begin
        if (any_req) begin
          state_next      = ST_OWNED;
          addr_owner_next = winner;
`ifndef RENODE_AHB_ARB_FIXED_PRIO_EN
          last_grant_next = winner;
`endif
        end else begin
          state_next = ST_IDLE;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    s_htrans  = HTRANS_IDLE;
    s_haddr   = '0;
    s_hwrite  = 1'b0;
    s_hsize   = '0;
    s_hburst  = '0;
    s_hmaster = '0;
    m_hready  = '0;
    m_hresp   = '0;
    if (state == ST_OWNED) begin
      s_htrans             = owner_htrans;
      s_haddr              = haddr_a[addr_owner];
      s_hwrite             = m_hwrite[addr_owner];
      s_hsize              = hsize_a[addr_owner];
      s_hburst             = hburst_a[addr_owner];
      s_hmaster            = addr_owner;
      m_hready[addr_owner] = s_hreadyout;
      m_hresp[addr_owner]  = s_hresp;
    end
    s_hwdata = data_valid ? hwdata_a[data_owner] : '0;
  end

  assign s_hready = s_hreadyout;
  assign m_hrdata = s_hrdata;

endmodule

// File: tb/tb_renode_ahb_arbiter.sv
// tb/tb_renode_ahb_arbiter.sv - directed scoreboard bench for renode_ahb_arbiter
module tb_renode_ahb_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [2*NM-1:0] m_htrans;
  logic [AW*NM-1:0] m_haddr;
  logic [NM-1:0]   m_hwrite;
  logic [3*NM-1:0] m_hsize;
  logic [3*NM-1:0] m_hburst;
  logic [DW*NM-1:0] m_hwdata;
  logic [NM-1:0]   m_hready;
  logic [NM-1:0]   m_hresp;
  logic [DW-1:0]   m_hrdata;
  logic [1:0]      s_htrans;
  logic [AW-1:0]   s_haddr;
  logic            s_hwrite;
  logic [2:0]      s_hsize;
  logic [2:0]      s_hburst;
  logic [DW-1:0]   s_hwdata;
  logic            s_hready;
  logic            s_hreadyout;
  logic            s_hresp;
  logic [DW-1:0]   s_hrdata;
  logic [0:0]      s_hmaster;

  renode_ahb_arbiter #(.NUM_MANAGERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
    .s_hrdata(s_hrdata), .s_hmaster(s_hmaster)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          m;
    logic [1:0]  tr;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic [31:0] wd;
  } beat_t;

  beat_t       mq0[$];
  beat_t       mq1[$];
  beat_t       sb[$];
  logic [31:0] last_wd [NM];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int m, input logic [1:0] tr, input logic [31:0] a,
                               input logic [2:0] bu, input logic [31:0] wd);
    beat_t b;
    b.m = m; b.tr = tr; b.addr = a; b.burst = bu; b.wd = wd;
    return b;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_mgr(input int i, input logic [1:0] tr, input logic [31:0] a,
                         input logic w, input logic [2:0] bu);
    m_htrans[2*i +: 2]  = tr;
    m_haddr[32*i +: 32] = a;
    m_hwrite[i]         = w;
    m_hsize[3*i +: 3]   = 3'b010;
    m_hburst[3*i +: 3]  = bu;
    m_hwdata[32*i +: 32] = last_wd[i];
  endtask

  task automatic drive_heads();
    if (mq0.size() > 0) set_mgr(0, mq0[0].tr, mq0[0].addr, 1'b1, mq0[0].burst);
    else                set_mgr(0, 2'b00, 32'h0, 1'b0, 3'b000);
    if (mq1.size() > 0) set_mgr(1, mq1[0].tr, mq1[0].addr, 1'b1, mq1[0].burst);
    else                set_mgr(1, 2'b00, 32'h0, 1'b0, 3'b000);
  endtask

  // Managers step through their beat lists: a request beat retires when the
  // manager sees its HREADY high, an IDLE beat retires after one cycle.
  // Every accepted address phase pops the scoreboard; its write data is
  // checked at the end of the following data phase.
  task automatic run_engine(input string name, input int budget);
    int          n;
    bit          dpend;
    beat_t       dexp;
    beat_t       e;
    logic [NM-1:0] rdy;
    n = 0;
    dpend = 0;
    dexp = mk(0, 2'b00, 0, 0, 0);
    while ((mq0.size() > 0 || mq1.size() > 0 || sb.size() > 0 || dpend) && n < budget) begin
      drive_heads();
      #1;
      if (dpend && s_hready) begin
        check({name, "_hwdata"}, s_hwdata, dexp.wd);
        dpend = 0;
      end
      if (s_htrans[1] && s_hready) begin
        if (sb.size() == 0) begin
          check({name, "_unexpected_xfer"}, s_htrans, 2'b00);
        end else begin
          e = sb.pop_front();
          check({name, "_hmaster"}, s_hmaster, e.m);
          check({name, "_haddr"}, s_haddr, e.addr);
          check({name, "_htrans"}, s_htrans, e.tr);
          check({name, "_hburst"}, s_hburst, e.burst);
          dexp  = e;
          dpend = 1;
        end
      end
      rdy = m_hready;
      tick();
      if (mq0.size() > 0 && (mq0[0].tr == 2'b00 || rdy[0])) begin
        if (mq0[0].tr != 2'b00) last_wd[0] = mq0[0].wd;
        void'(mq0.pop_front());
      end
      if (mq1.size() > 0 && (mq1[0].tr == 2'b00 || rdy[1])) begin
        if (mq1[0].tr != 2'b00) last_wd[1] = mq1[0].wd;
        void'(mq1.pop_front());
      end
      n++;
    end
    check({name, "_sb_left"}, sb.size(), 0);
    check({name, "_in_budget"}, (n < budget), 1'b1);
  endtask

  initial begin
    beat_t e;
    int    lo;
    int    hi;
    bit    m1resp;

    HRESETn = 1'b0;
    m_htrans = '0; m_haddr = '0; m_hwrite = '0; m_hsize = '0; m_hburst = '0; m_hwdata = '0;
    s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    last_wd[0] = '0; last_wd[1] = '0;

    // 1: reset state, then idle bus with no requests
    tick(); tick();
    check("rst_htrans", s_htrans, 2'b00);
    check("rst_hready", m_hready, 2'b00);
    check("rst_hmaster", s_hmaster, 1'b0);
    check("rst_haddr", s_haddr, 32'h0);
    check("rst_hwdata", s_hwdata, 32'h0);
    HRESETn = 1'b1;
    tick(); tick(); tick();
    check("idle_htrans", s_htrans, 2'b00);
    check("idle_hready", m_hready, 2'b00);

    // 2: single M0 write
    sb.push_back(mk(0, 2'b10, 32'h1000, 3'b000, 32'hDEADBEEF));
    set_mgr(0, 2'b10, 32'h1000, 1'b1, 3'b000);
    #1;
    check("t2_not_yet_granted", s_htrans, 2'b00);
    check("t2_not_yet_ready", m_hready, 2'b00);
    tick();
    e = sb.pop_front();
    check("t2_htrans", s_htrans, e.tr);
    check("t2_haddr", s_haddr, e.addr);
    check("t2_hmaster", s_hmaster, e.m);
    check("t2_hwrite", s_hwrite, 1'b1);
    check("t2_hready_addr", m_hready, 2'b01);
    tick();
    last_wd[0] = e.wd;
    set_mgr(0, 2'b00, 32'h0, 1'b0, 3'b000);
    #1;
    check("t2_hwdata", s_hwdata, e.wd);
    check("t2_m0_hready", m_hready[0], 1'b1);
    check("t2_m1_hready", m_hready[1], 1'b0);
    tick();
    check("t2_released_htrans", s_htrans, 2'b00);
    check("t2_released_hready", m_hready, 2'b00);

    // 3: both managers request repeatedly, idling one cycle between transfers
    mq0.push_back(mk(0, 2'b10, 32'h100, 3'b000, 32'hA0A0_0000));
    mq0.push_back(mk(0, 2'b00, 32'h0,   3'b000, 32'h0));
    mq0.push_back(mk(0, 2'b10, 32'h104, 3'b000, 32'hA0A0_0001));
    mq1.push_back(mk(1, 2'b10, 32'h200, 3'b000, 32'hB1B1_0000));
    mq1.push_back(mk(1, 2'b00, 32'h0,   3'b000, 32'h0));
    mq1.push_back(mk(1, 2'b10, 32'h204, 3'b000, 32'hB1B1_0001));
`ifdef RENODE_AHB_ARB_FIXED_PRIO_EN
    sb.push_back(mq0[0]); sb.push_back(mq1[0]); sb.push_back(mq0[2]); sb.push_back(mq1[2]);
`else
    // last grant was M0, so the search starts at M1
    sb.push_back(mq1[0]); sb.push_back(mq0[0]); sb.push_back(mq1[2]); sb.push_back(mq0[2]);
`endif
    run_engine("t3", 40);

    // 4: M1 INCR4 burst keeps the bus while M0 waits
    mq1.push_back(mk(1, 2'b10, 32'h2000, 3'b011, 32'hC000_0000));
    mq1.push_back(mk(1, 2'b11, 32'h2004, 3'b011, 32'hC000_0001));
    mq1.push_back(mk(1, 2'b11, 32'h2008, 3'b011, 32'hC000_0002));
    mq1.push_back(mk(1, 2'b11, 32'h200C, 3'b011, 32'hC000_0003));
    mq0.push_back(mk(0, 2'b00, 32'h0,   3'b000, 32'h0));
    mq0.push_back(mk(0, 2'b10, 32'h500, 3'b000, 32'hD000_0000));
    for (int k = 0; k < 4; k++) sb.push_back(mq1[k]);
    sb.push_back(mq0[1]);
    run_engine("t4", 40);

    // 5: M0 read with wait states and a two-cycle ERROR; M1 waits meanwhile
    s_hrdata = 32'h3000_CAFE;
    set_mgr(0, 2'b10, 32'h3000, 1'b0, 3'b000);
    set_mgr(1, 2'b00, 32'h0, 1'b0, 3'b000);
    tick();
    check("t5_haddr", s_haddr, 32'h3000);
    check("t5_hwrite", s_hwrite, 1'b0);
    check("t5_hready_addr", m_hready, 2'b01);
    tick();
    set_mgr(0, 2'b00, 32'h0, 1'b0, 3'b000);
    set_mgr(1, 2'b10, 32'h4000, 1'b1, 3'b000);
    lo = 0; hi = 0; m1resp = 0;
    for (int k = 0; k < 4; k++) begin
      s_hreadyout = (k == 3);
      s_hresp     = (k >= 2);
      #1;
      if (!m_hready[0]) lo++;
      if (m_hresp[0]) hi++;
      if (m_hresp[1]) m1resp = 1;
      check("t5_owner_frozen", s_hmaster, 1'b0);
      check("t5_hrdata", m_hrdata, 32'h3000_CAFE);
      tick();
    end
    s_hreadyout = 1'b1;
    s_hresp     = 1'b0;
    check("t5_m0_hready_low_cycles", lo, 3);
    check("t5_m0_hresp_cycles", hi, 2);
    check("t5_m1_hresp", m1resp, 1'b0);
    #1;
    check("t5_m1_granted", s_hmaster, 1'b1);
    check("t5_m1_haddr", s_haddr, 32'h4000);
    check("t5_m1_hready", m_hready, 2'b10);
    tick();

    // 6: reset during M1 data phase
    last_wd[1] = 32'h4444_4444;
    set_mgr(1, 2'b00, 32'h0, 1'b0, 3'b000);
    #1;
    check("t6_hwdata_before", s_hwdata, 32'h4444_4444);
    HRESETn = 1'b0;
    #1;
    check("t6_rst_htrans", s_htrans, 2'b00);
    check("t6_rst_hready", m_hready, 2'b00);
    check("t6_rst_hresp", m_hresp, 2'b00);
    check("t6_rst_hwdata", s_hwdata, 32'h0);
    check("t6_rst_haddr", s_haddr, 32'h0);
    check("t6_rst_hmaster", s_hmaster, 1'b0);
    tick();
    HRESETn = 1'b1;
    set_mgr(0, 2'b10, 32'h5000, 1'b1, 3'b000);
    #1;
    check("t6_post_not_yet", s_htrans, 2'b00);
    tick();
    check("t6_post_htrans", s_htrans, 2'b10);
    check("t6_post_haddr", s_haddr, 32'h5000);
    check("t6_post_hready", m_hready, 2'b01);
    tick();
    set_mgr(0, 2'b00, 32'h0, 1'b0, 3'b000);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
